// File: rtl/cga_video_pkg.sv
// Shared CGA video definitions: IRGB bit positions, BGR pixel layout,
// pending-write states and the default CGA palette.
package cga_video_pkg;

    localparam int I_BIT = 3;
    localparam int R_BIT = 2;
    localparam int G_BIT = 1;
    localparam int B_BIT = 0;

    localparam int PAL_N = 16;
    localparam logic [3:0] BROWN_IDX = 4'd6;

    // Packed as {B[17:12], G[11:6], R[5:0]}
    typedef struct packed {
        logic [5:0] b;
        logic [5:0] g;
        logic [5:0] r;
    } bgr_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_PEND,
        WR_COMMIT
    } wr_state_t;

    function automatic bgr_t default_pal(
        input logic [3:0] idx,
        input logic [5:0] base,
        input logic [5:0] bright
    );
        bgr_t c;
        logic [5:0] add;
        add = idx[I_BIT] ? bright : 6'h00;
        c.r = (idx[R_BIT] ? base : 6'h00) + add;
        c.g = (idx[G_BIT] ? base : 6'h00) + add;
        c.b = (idx[B_BIT] ? base : 6'h00) + add;
        // Dark yellow is shown as brown on real CGA monitors
        if (idx == BROWN_IDX) begin
            c.r = base;
            c.g = bright;
            c.b = 6'h00;
        end
        return c;
    endfunction

endpackage

// File: rtl/cga_palette_ram.sv
// 16x18 palette register file: one write port, one async read port,
// synchronous reload of the CGA defaults on reset.
import cga_video_pkg::*;

module cga_palette_ram #(
    parameter logic [5:0] BRIGHT_LVL = 6'h15,
    parameter logic [5:0] BASE_LVL   = 6'h2A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [17:0] wdata,
    input  logic [3:0]  raddr,
    output logic [17:0] rdata
);

    logic [17:0] mem [PAL_N];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                mem[i] <= default_pal(4'(i), BASE_LVL, BRIGHT_LVL);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cga_irgb_palette.sv
// CGA IRGB to 18-bit VGA DAC expander: 2-stage pixel pipeline with
// matched sync/de delay and optionally vsync-deferred palette writes.
import cga_video_pkg::*;

module cga_irgb_palette #(
    parameter bit         SAFE_WRITE = 1'b1,
    parameter logic [5:0] BRIGHT_LVL = 6'h15,
    parameter logic [5:0] BASE_LVL   = 6'h2A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_ce,
    input  logic [3:0]  video,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [17:0] pal_data,
    output logic        pal_busy,
    output logic [17:0] bgr,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    wr_state_t   state;
    logic [3:0]  pend_addr;
    logic [17:0] pend_data;

    logic        ram_we;
    logic [3:0]  ram_waddr;
    logic [17:0] ram_wdata;
    logic [17:0] ram_rdata;

    logic [3:0]  s1_video;
    logic        s1_de;
    logic        s1_hs;
    logic        s1_vs;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = pal_addr;
        ram_wdata = pal_data;
        if (SAFE_WRITE) begin
            ram_we    = (state == WR_PEND) && vsync_in;
            ram_waddr = pend_addr;
            ram_wdata = pend_data;
        end else begin
            ram_we    = pal_we;
        end
    end

    // Busy is a flop so it changes only on the clock after the event
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= WR_IDLE;
            pal_busy  <= 1'b0;
            pend_addr <= 4'h0;
            pend_data <= 18'h0;
        end else begin
            unique case (state)
                WR_IDLE: begin
                    if (SAFE_WRITE && pal_we) begin
                        pend_addr <= pal_addr;
                        pend_data <= pal_data;
                        state     <= WR_PEND;
                        pal_busy  <= 1'b1;
                    end
                end
                WR_PEND: begin
                    if (vsync_in) begin
                        state <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    state    <= WR_IDLE;
                    pal_busy <= 1'b0;
                end
                default: begin
                    state    <= WR_IDLE;
                    pal_busy <= 1'b0;
                end
            endcase
        end
    end

    cga_palette_ram #(
        .BRIGHT_LVL (BRIGHT_LVL),
        .BASE_LVL   (BASE_LVL)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr   (s1_video),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_video  <= 4'h0;
            s1_de     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            bgr       <= 18'h0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else if (pix_ce) begin
            s1_video  <= video;
            s1_de     <= de_in;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
            bgr       <= s1_de ? ram_rdata : 18'h0;
            de_out    <= s1_de;
            hsync_out <= s1_hs;
            vsync_out <= s1_vs;
        end
    end

endmodule

// File: tb/tb_cga_irgb_palette.sv
// Bench for cga_irgb_palette: one SAFE_WRITE=1 and one SAFE_WRITE=0 instance
// on shared stimulus, compared every clock against a behavioural model.
module tb_cga_irgb_palette;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_ce;
    logic [3:0]  video;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [17:0] pal_data;

    logic        busy0, busy1;
    logic [17:0] bgr0, bgr1;
    logic        de0, de1, hs0, hs1, vs0, vs1;

    int total = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cga_irgb_palette #(.SAFE_WRITE(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .video(video),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .pal_busy(busy0), .bgr(bgr0), .de_out(de0),
        .hsync_out(hs0), .vsync_out(vs0)
    );

    cga_irgb_palette #(.SAFE_WRITE(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .video(video),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .pal_busy(busy1), .bgr(bgr1), .de_out(de1),
        .hsync_out(hs1), .vsync_out(vs1)
    );

    // Reference model state
    logic [17:0] m_pal0 [16];
    logic [17:0] m_pal1 [16];
    logic [3:0]  m_s1v;
    logic        m_s1de, m_s1hs, m_s1vs;
    logic [17:0] m_bgr0, m_bgr1;
    logic        m_de, m_hs, m_vs;
    logic        m_pend, m_tail;
    logic [3:0]  m_pa;
    logic [17:0] m_pd;

    function automatic logic [17:0] dflt(input int i);
        int r, g, b, add;
        add = ((i >> 3) & 1) * 21;
        r = ((i >> 2) & 1) * 42 + add;
        g = ((i >> 1) & 1) * 42 + add;
        b = (i & 1) * 42 + add;
        if (i == 6) begin
            r = 42; g = 21; b = 0;
        end
        return {6'(b), 6'(g), 6'(r)};
    endfunction

    task automatic model_update();
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                m_pal0[i] = dflt(i);
                m_pal1[i] = dflt(i);
            end
            m_s1v = 0; m_s1de = 0; m_s1hs = 0; m_s1vs = 0;
            m_bgr0 = 0; m_bgr1 = 0; m_de = 0; m_hs = 0; m_vs = 0;
            m_pend = 0; m_tail = 0; m_pa = 0; m_pd = 0;
        end else begin
            if (pix_ce) begin
                m_bgr0 = m_s1de ? m_pal0[m_s1v] : 18'h0;
                m_bgr1 = m_s1de ? m_pal1[m_s1v] : 18'h0;
                m_de = m_s1de; m_hs = m_s1hs; m_vs = m_s1vs;
                m_s1v = video; m_s1de = de_in;
                m_s1hs = hsync_in; m_s1vs = vsync_in;
            end
            if (pal_we) m_pal0[pal_addr] = pal_data;
            if (m_tail) begin
                m_tail = 0;
            end else if (m_pend) begin
                if (vsync_in) begin
                    m_pal1[m_pa] = m_pd;
                    m_pend = 0;
                    m_tail = 1;
                end
            end else if (pal_we) begin
                m_pend = 1;
                m_pa = pal_addr;
                m_pd = pal_data;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [17:0] obs,
                       input logic [17:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("bgr0", bgr0, m_bgr0);
        chk("bgr1", bgr1, m_bgr1);
        chk("de0", 18'(de0), 18'(m_de));
        chk("de1", 18'(de1), 18'(m_de));
        chk("hs0", 18'(hs0), 18'(m_hs));
        chk("hs1", 18'(hs1), 18'(m_hs));
        chk("vs0", 18'(vs0), 18'(m_vs));
        chk("vs1", 18'(vs1), 18'(m_vs));
        chk("busy0", 18'(busy0), 18'h0);
        chk("busy1", 18'(busy1), 18'(m_pend | m_tail));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic randomize_inputs(input bit allow_reset);
        reset_n  = allow_reset ? ($urandom_range(0, 49) != 0) : 1'b1;
        pix_ce   = 1'($urandom);
        video    = 4'($urandom);
        de_in    = 1'($urandom);
        hsync_in = 1'($urandom);
        vsync_in = ($urandom_range(0, 9) == 0);
        pal_we   = ($urandom_range(0, 7) == 0);
        pal_addr = 4'($urandom);
        pal_data = 18'($urandom);
    endtask

    initial begin
        reset_n = 0; pix_ce = 0; video = 0; de_in = 0;
        hsync_in = 0; vsync_in = 0; pal_we = 0; pal_addr = 0; pal_data = 0;
        tick();

        // Activity, then reset mid-line with pix_ce toggling
        for (int k = 0; k < 20; k++) begin
            randomize_inputs(1'b0);
            tick();
        end
        reset_n = 0; pix_ce = ~pix_ce; pal_we = 0;
        tick();
        chk("rst_bgr1", bgr1, 18'h0);
        chk("rst_de1", 18'(de1), 18'h0);
        chk("rst_busy1", 18'(busy1), 18'h0);
        reset_n = 1; pix_ce = 1; hsync_in = 0; vsync_in = 0;

        video = 4'h5; de_in = 1;
        tick(); tick();
        chk("entry5", bgr1, {6'h2A, 6'h00, 6'h2A});

        // E with aligned sync/de, then drop inputs
        video = 4'hE; de_in = 1; hsync_in = 1;
        tick();
        video = 4'h0; de_in = 0; hsync_in = 0;
        tick();
        chk("entryE", bgr1, {6'h15, 6'h3F, 6'h3F});
        chk("entryE_de", 18'(de1), 18'h1);
        chk("entryE_hs", 18'(hs1), 18'h1);

        video = 4'h6; de_in = 1;
        tick(); tick();
        chk("brown", bgr0, {6'h00, 6'h15, 6'h2A});
        de_in = 0;
        tick(); tick();
        chk("blank_bgr", bgr1, 18'h0);
        chk("blank_de", 18'(de1), 18'h0);

        // pix_ce every 4th clock
        video = 4'h9; de_in = 1;
        for (int k = 0; k < 8; k++) begin
            pix_ce = (k % 4 == 0);
            tick();
            if (k == 4 || k == 7) chk("slow_ce9", bgr1, {6'h3F, 6'h15, 6'h15});
        end
        pix_ce = 1;

        // Deferred write on the SAFE_WRITE=1 instance
        vsync_in = 0; pal_we = 1; pal_addr = 4'h1; pal_data = 18'h3FFFF;
        tick();
        pal_we = 0; video = 4'h1; de_in = 1;
        chk("pend_busy", 18'(busy1), 18'h1);
        tick();
        pal_we = 1; pal_addr = 4'h2; pal_data = 18'h00000;
        tick();
        pal_we = 0;
        chk("pend_old1", bgr1, {6'h2A, 6'h00, 6'h00});
        vsync_in = 1;
        tick();
        vsync_in = 0;
        chk("commit_busy", 18'(busy1), 18'h1);
        tick();
        chk("commit_idle", 18'(busy1), 18'h0);
        tick();
        chk("new1", bgr1, 18'h3FFFF);
        video = 4'h2;
        tick(); tick();
        chk("ignored2", bgr1, {6'h00, 6'h2A, 6'h00});

        // Same-edge write/lookup on the SAFE_WRITE=0 instance
        video = 4'h3;
        tick(); tick();
        pal_we = 1; pal_addr = 4'h3; pal_data = 18'h12345;
        tick();
        pal_we = 0;
        chk("same_edge_old", bgr0, {6'h2A, 6'h2A, 6'h00});
        tick();
        chk("same_edge_new", bgr0, 18'h12345);

        for (int k = 0; k < 400; k++) begin
            randomize_inputs(1'b1);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
